// File: rtl/field_scanner.sv
// Snapshots the packed game field on a frame request and streams it out one cell
// per valid/ready handshake in raster order, tallying snake and apple cells per frame.
module field_scanner #(
  parameter int unsigned SIZE_X     = 10,
  parameter int unsigned SIZE_Y     = 10,
  parameter int unsigned FIELD_SIZE = SIZE_X * SIZE_Y * 2,
  parameter int unsigned CELLS      = SIZE_X * SIZE_Y
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [FIELD_SIZE-1:0] field,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [1:0]            out_cell,
  output logic [7:0]            out_x,
  output logic [7:0]            out_y,
  output logic                  out_first,
  output logic                  out_last,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           snake_cells,
  output logic [15:0]           apple_cells
);

  localparam int unsigned IW         = (FIELD_SIZE > 2) ? $clog2(FIELD_SIZE) : 1;
  localparam logic [7:0]  X_MAX      = 8'(SIZE_X - 1);
  localparam logic [15:0] IDX_MAX    = 16'(CELLS - 1);
  localparam logic [1:0]  CELL_SNAKE = 2'b01;
  localparam logic [1:0]  CELL_APPLE = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state, state_n;
  logic [FIELD_SIZE-1:0]   shadow, shadow_n;
  logic [15:0]             idx, idx_n;
  logic [7:0]              x_n, y_n;
  logic [1:0]              cell_n;
  logic                    first_n, last_n;
  logic                    valid_n, busy_n, done_n;
  logic [15:0]             snake_run, snake_run_n;
  logic [15:0]             apple_run, apple_run_n;
  logic [15:0]             snake_n, apple_n;
  logic [15:0]             snake_inc, apple_inc;
  logic [15:0]             next_idx;
  logic [IW-1:0]           bit_off;

  // Next-state and next-output logic; all outputs are registered from these values
  always_comb begin
    state_n     = state;
    shadow_n    = shadow;
    idx_n       = idx;
    x_n         = out_x;
    y_n         = out_y;
    cell_n      = out_cell;
    first_n     = out_first;
    last_n      = out_last;
    valid_n     = 1'b0;
    busy_n      = 1'b0;
    done_n      = 1'b0;
    snake_run_n = snake_run;
    apple_run_n = apple_run;
    snake_n     = snake_cells;
    apple_n     = apple_cells;
    snake_inc   = 16'(out_cell == CELL_SNAKE);
    apple_inc   = 16'(out_cell == CELL_APPLE);
    next_idx    = idx + 16'd1;
    bit_off     = IW'({next_idx, 1'b0});

    case (state)
      IDLE: begin
        if (start) begin
          state_n     = SCAN;
          shadow_n    = field;
          idx_n       = 16'd0;
          x_n         = 8'd0;
          y_n         = 8'd0;
          cell_n      = field[1:0];
          first_n     = 1'b1;
          last_n      = (CELLS == 32'd1);
          snake_run_n = 16'd0;
          apple_run_n = 16'd0;
          valid_n     = 1'b1;
          busy_n      = 1'b1;
        end
      end

      SCAN: begin
        valid_n = 1'b1;
        busy_n  = 1'b1;
        if (out_ready) begin
          if (out_last) begin
            // Final cell: publish totals including this cell, present no wrap
            state_n = DONE;
            valid_n = 1'b0;
            done_n  = 1'b1;
            snake_n = snake_run + snake_inc;
            apple_n = apple_run + apple_inc;
            idx_n   = 16'd0;
            x_n     = 8'd0;
            y_n     = 8'd0;
            cell_n  = 2'b00;
            first_n = 1'b0;
            last_n  = 1'b0;
          end else begin
            snake_run_n = snake_run + snake_inc;
            apple_run_n = apple_run + apple_inc;
            idx_n       = next_idx;
            if (out_x == X_MAX) begin
              x_n = 8'd0;
              y_n = out_y + 8'd1;
            end else begin
              x_n = out_x + 8'd1;
            end
            cell_n  = shadow[bit_off +: 2];
            first_n = 1'b0;
            last_n  = (next_idx == IDX_MAX);
          end
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any frame immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      shadow      <= '0;
      idx         <= 16'd0;
      out_x       <= 8'd0;
      out_y       <= 8'd0;
      out_cell    <= 2'b00;
      out_first   <= 1'b0;
      out_last    <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      snake_run   <= 16'd0;
      apple_run   <= 16'd0;
      snake_cells <= 16'd0;
      apple_cells <= 16'd0;
    end else begin
      state       <= state_n;
      shadow      <= shadow_n;
      idx         <= idx_n;
      out_x       <= x_n;
      out_y       <= y_n;
      out_cell    <= cell_n;
      out_first   <= first_n;
      out_last    <= last_n;
      out_valid   <= valid_n;
      busy        <= busy_n;
      frame_done  <= done_n;
      snake_run   <= snake_run_n;
      apple_run   <= apple_run_n;
      snake_cells <= snake_n;
      apple_cells <= apple_n;
    end
  end

endmodule

// File: tb/tb_field_scanner.sv
// Directed self-checking bench for field_scanner on a 10x10 field.
module tb_field_scanner;

  localparam int SX    = 10;
  localparam int SY    = 10;
  localparam int NC    = SX * SY;
  localparam int FS    = NC * 2;
  localparam int MAXC  = 400;

  logic          clk;
  logic          rst;
  logic          start;
  logic [FS-1:0] fld;
  logic          out_ready;
  logic          out_valid;
  logic [1:0]    out_cell;
  logic [7:0]    out_x;
  logic [7:0]    out_y;
  logic          out_first;
  logic          out_last;
  logic          busy;
  logic          frame_done;
  logic [15:0]   snake_cells;
  logic [15:0]   apple_cells;

  field_scanner #(.SIZE_X(SX), .SIZE_Y(SY)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .field       (fld),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_cell    (out_cell),
    .out_x       (out_x),
    .out_y       (out_y),
    .out_first   (out_first),
    .out_last    (out_last),
    .busy        (busy),
    .frame_done  (frame_done),
    .snake_cells (snake_cells),
    .apple_cells (apple_cells)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [19:0] exp;
  } vec_t;

  int            n_pass = 0;
  int            n_chk  = 0;
  logic [FS-1:0] snap;
  logic [FS-1:0] base_fld;
  logic [19:0]   rec [NC];
  vec_t          tbl [5];
  int            dcyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Expected {x, y, code, first, last} for raster cell n of the current snapshot
  function automatic logic [19:0] exp_cell(input int n);
    logic [1:0] code;
    code = snap[2*n +: 2];
    return {8'(n % SX), 8'(n / SX), code, (n == 0), (n == NC - 1)};
  endfunction

  function automatic logic [19:0] act_cell();
    return {out_x, out_y, out_cell, out_first, out_last};
  endfunction

  // Runs one frame from a negedge; mode 0 ready=1, 1 ready 1,0,0, 2 mid-scan disturbance, 3 abort at cell 50
  task automatic scan(input int mode, input logic [15:0] prev_s, input logic [15:0] prev_a,
                      output int done_cyc);
    int  n_acc;
    bit  injected;
    bit  r;
    n_acc    = 0;
    injected = 0;
    done_cyc = -1;
    snap      = fld;
    start     = 1'b1;
    out_ready = 1'b1;
    for (int c = 1; c <= MAXC; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 1) begin
        check("counts_hold_snake", 32'(snake_cells), 32'(prev_s));
        check("counts_hold_apple", 32'(apple_cells), 32'(prev_a));
      end
      if (mode == 2 && n_acc == 21 && !injected) begin
        fld      = '1;
        start    = 1'b1;
        injected = 1;
      end
      if (mode == 3 && n_acc == 50) return;
      if (n_acc < NC) begin
        check("valid_in_scan", 32'(out_valid), 32'd1);
        check("busy_in_scan", 32'(busy), 32'd1);
        check($sformatf("cell%0d", n_acc), 32'(act_cell()), 32'(exp_cell(n_acc)));
        r = (mode == 1) ? ((c - 1) % 3 == 0) : 1'b1;
        out_ready = r;
        if (r) begin
          rec[n_acc] = act_cell();
          n_acc++;
        end
      end else begin
        check("done_pulse", 32'(frame_done), 32'd1);
        check("done_valid", 32'(out_valid), 32'd0);
        check("done_busy", 32'(busy), 32'd1);
        done_cyc  = c;
        out_ready = 1'b0;
        return;
      end
    end
    $display("FAIL frame_timeout: got no frame_done within %0d cycles", MAXC);
    n_chk++;
  endtask

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    fld       = '0;
    fld[1:0]  = 2'b10;
    fld[3:2]  = 2'b01;
    fld[5:4]  = 2'b01;
    fld[7:6]  = 2'b01;
    base_fld  = fld;

    tbl[0] = '{0,  {8'd0, 8'd0, 2'b10, 1'b1, 1'b0}};
    tbl[1] = '{3,  {8'd3, 8'd0, 2'b01, 1'b0, 1'b0}};
    tbl[2] = '{9,  {8'd9, 8'd0, 2'b00, 1'b0, 1'b0}};
    tbl[3] = '{10, {8'd0, 8'd1, 2'b00, 1'b0, 1'b0}};
    tbl[4] = '{99, {8'd9, 8'd9, 2'b00, 1'b0, 1'b1}};

    #1;
    check("reset_outputs", 32'({out_valid, busy, frame_done, out_first, out_last}), 32'd0);
    check("reset_counts", 32'({snake_cells, apple_cells}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Idle with no request
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_quiet", 32'({out_valid, busy, frame_done}), 32'd0);
      check("idle_counts", 32'({snake_cells, apple_cells}), 32'd0);
    end

    // Frame A: ready held high
    scan(0, 16'd0, 16'd0, dcyc);
    check("A_done_cycle", 32'(dcyc), 32'd101);
    check("A_snake", 32'(snake_cells), 32'd3);
    check("A_apple", 32'(apple_cells), 32'd1);
    for (int i = 0; i < 5; i++)
      check($sformatf("tbl%0d", tbl[i].idx), 32'(rec[tbl[i].idx]), 32'(tbl[i].exp));

    // Frame B: ready toggling 1,0,0
    @(negedge clk);
    check("idle_after_done", 32'({busy, out_valid, frame_done}), 32'd0);
    scan(1, 16'd3, 16'd1, dcyc);
    check("B_done_cycle", 32'(dcyc), 32'd299);
    check("B_snake", 32'(snake_cells), 32'd3);
    check("B_apple", 32'(apple_cells), 32'd1);

    // Frame C: field overwritten and start pulsed mid-scan
    @(negedge clk);
    scan(2, 16'd3, 16'd1, dcyc);
    check("C_done_cycle", 32'(dcyc), 32'd101);
    check("C_snake", 32'(snake_cells), 32'd3);
    check("C_apple", 32'(apple_cells), 32'd1);
    fld = base_fld;

    // Frame D: reset at cell 50
    @(negedge clk);
    scan(3, 16'd3, 16'd1, dcyc);
    rst = 1'b0;
    #1;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_counts", 32'({snake_cells, apple_cells}), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'({frame_done, out_valid}), 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_idle", 32'({busy, frame_done}), 32'd0);
    scan(0, 16'd0, 16'd0, dcyc);
    check("D2_done_cycle", 32'(dcyc), 32'd101);
    check("D2_snake", 32'(snake_cells), 32'd3);
    check("D2_apple", 32'(apple_cells), 32'd1);

    // Frame E: back-to-back with a new field of 5 snakes, no apples
    @(negedge clk);
    fld = '0;
    for (int i = 40; i < 45; i++) fld[2*i +: 2] = 2'b01;
    scan(0, 16'd3, 16'd1, dcyc);
    check("E_done_cycle", 32'(dcyc), 32'd101);
    check("E_snake", 32'(snake_cells), 32'd5);
    check("E_apple", 32'(apple_cells), 32'd0);
    @(negedge clk);
    check("E_counts_hold", 32'({snake_cells, apple_cells}), {16'd5, 16'd0});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/field_scanner.md
Name: field_scanner

Overview:
- Reads the packed 2-bit-per-cell field vector produced by the game-state block.
- Snapshots it on a frame request and streams it out one cell per handshake, in raster order, to the display or LED-matrix driver.
- Tallies snake and apple cells per frame so the display side can cross-check the game state.
- Sits between field generation and the screen driver.

Parameters:
- SIZE_X, 10, field width in cells (1..255)
- SIZE_Y, 10, field height in cells (1..255)
- FIELD_SIZE, SIZE_X*SIZE_Y*2, packed field width in bits
- CELLS, SIZE_X*SIZE_Y, cells per frame

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  frame request; typically the step-delayed strobe from field generation
- field  in  FIELD_SIZE  packed field; cell i = field[2i+1:2i]; 00 empty, 01 snake, 10 apple, 11 block
- out_ready  in  1  downstream accepts current cell
- out_valid  out  1  current cell data valid
- out_cell  out  2  cell code
- out_x  out  8  cell column, 0..SIZE_X-1
- out_y  out  8  cell row, 0..SIZE_Y-1
- out_first  out  1  current cell is (0,0)
- out_last  out  1  current cell is (SIZE_X-1,SIZE_Y-1)
- busy  out  1  frame in progress (SCAN or DONE)
- frame_done  out  1  one-cycle pulse after last cell accepted
- snake_cells  out  16  count of 01 cells in last completed frame
- apple_cells  out  16  count of 10 cells in last completed frame

Behaviour:
- Reset (rst low, async): state IDLE; idx, x, y = 0; shadow field = 0.
  - All outputs 0, including snake_cells and apple_cells.
  - Release is synchronous to clk.
- Cell index: idx = y*SIZE_X + x. Data path: out_cell = shadow[2*idx+1:2*idx].
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - out_valid = 0, busy = 0.
  - When start = 1 at edge k: copy field into shadow; clear x, y and the running counters; go to SCAN.
  - out_valid = 1 from cycle k+1 with cell (0,0).
- SCAN:
  - out_valid = 1, busy = 1.
  - Transfer occurs on an edge where out_valid and out_ready are both 1.
  - On transfer, increment the running counter selected by out_cell (01 -> snake, 10 -> apple; 00 and 11 uncounted).
  - Then advance: x+1; if x = SIZE_X-1, x = 0 and y+1.
  - While out_ready = 0, out_cell, out_x, out_y, out_first and out_last hold stable and out_valid stays 1.
- Last-cell transfer:
  - Go to DONE.
  - Latch final counts, including the last cell, into snake_cells and apple_cells.
  - No wrap to (0,0) is presented.
- DONE:
  - One cycle; frame_done = 1, busy = 1, out_valid = 0.
  - Then go to IDLE.
- start while busy (SCAN or DONE): ignored, no queuing. The shadow field is not disturbed, so there is no tearing.
- start in the first IDLE cycle after DONE: accepted normally.
- Changes on field after the snapshot have no effect until the next start.
- Throughput with out_ready held 1: one cell per cycle. A frame is CELLS cycles in SCAN plus 1 in DONE, i.e. start to frame_done = CELLS+1 cycles.
- Count widths: 16 bits, never saturate, since CELLS <= 65025.
- snake_cells and apple_cells hold until the next frame_done.
- Reset mid-frame: immediate abort.
  - out_valid drops asynchronously.
  - Counts clear to 0.
  - No frame_done is issued.
- out_first = (x = 0 and y = 0) and out_valid. out_last = (idx = CELLS-1) and out_valid.

Test Plan:
- Reset then idle, with start = 0 for 20 cycles -> out_valid, busy, frame_done stay 0; counts stay 0.
- 10x10 field with cell 0 = 10 and cells 1..3 = 01, others 00; out_ready = 1; start pulse -> 100 consecutive valid cells.
  - First cell (0,0) code 10 with out_first = 1.
  - Cell (3,0) code 01.
  - out_last at (9,9).
  - frame_done exactly 101 cycles after start.
  - snake_cells = 3, apple_cells = 1.
- Same frame, out_ready toggling 1,0,0,1... -> each cell is held stable while ready = 0.
  - The sequence of (x,y,code) is identical to the ready = 1 run.
  - Counts are unchanged at 3 and 1.
- Mid-scan stimulus: after cell 20 is accepted, change field to all 11 and pulse start -> both are ignored; remaining cells follow the original snapshot; frame completes normally.
- Mid-scan reset: assert rst low at cell 50 -> out_valid and busy go 0 without waiting for clk; counts read 0; no frame_done.
  - A new start after release scans again from (0,0).
- Back-to-back: start asserted the cycle after frame_done -> accepted; second frame counts reflect the field at the new snapshot.
  - Example: field changed to 5 snake cells and 0 apples -> snake_cells = 5, apple_cells = 0.
